wb_vmon_txn_monitor: RTL and testbench

//   Passive Wishbone bus monitor, attached to master port 0 of the SoC peripheral interconnect.

---
 rtl/wb_vmon_txn_monitor.sv | 110 +++++++++++
 tb/tb_wb_vmon_txn_monitor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_vmon_txn_monitor.sv
// Passive Wishbone transfer monitor.
// Queues completed transfers into a show-ahead FIFO and keeps bus statistics.
module wb_vmon_txn_monitor #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int WAIT_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   ADR,
  input  logic [DATA_WIDTH-1:0]   DAT_W,
  input  logic                    CYC,
  input  logic                    STB,
  input  logic                    WE,
  input  logic [DATA_WIDTH/8-1:0] SEL,
  input  logic                    ACK,
  input  logic                    ERR,
  output logic                    txn_valid_o,
  input  logic                    txn_ready_i,
  output logic [ADDR_WIDTH-1:0]   txn_adr_o,
  output logic [DATA_WIDTH-1:0]   txn_dat_o,
  output logic [DATA_WIDTH/8-1:0] txn_sel_o,
  output logic                    txn_we_o,
  output logic                    txn_err_o,
  output logic [WAIT_WIDTH-1:0]   txn_wait_o,
  output logic [31:0]             txn_count_o,
  output logic [15:0]             drop_count_o,
  output logic                    overflow_o,
  output logic                    proto_err_o
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = ADDR_WIDTH + DATA_WIDTH + SW + 2 + WAIT_WIDTH;

  logic [RW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [CW-1:0]         cnt;
  logic [WAIT_WIDTH-1:0] wcnt;

  logic          act;
  logic          term;
  logic          pop;
  logic          full;
  logic          wr;
  logic          drop;
  logic          viol;
  logic [RW-1:0] rec;
  logic [RW-1:0] head;

  assign act  = CYC & STB;
  assign term = act & (ACK | ERR);
  assign viol = ((ACK | ERR) & ~act) | (ACK & ERR);
  assign full = (cnt == CW'(FIFO_DEPTH));
  assign pop  = txn_valid_o & txn_ready_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr   = term & (~full | pop);
  assign drop = term & full & ~pop;
  assign rec  = {ADR, DAT_W, SEL, WE, ERR, wcnt};

  assign txn_valid_o = (cnt != '0);
  assign head        = txn_valid_o ? mem[rptr] : '0;
  assign {txn_adr_o, txn_dat_o, txn_sel_o,
          txn_we_o, txn_err_o, txn_wait_o} = head;

  always_ff @(posedge clk_i) begin
    if (wr) mem[wptr] <= rec;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr)  wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      cnt <= cnt + CW'(wr) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wcnt <= '0;
    end else if (!act || term) begin
      wcnt <= '0;
    end else if (wcnt != '1) begin
      wcnt <= wcnt + WAIT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      txn_count_o  <= '0;
      drop_count_o <= '0;
      overflow_o   <= 1'b0;
      proto_err_o  <= 1'b0;
    end else begin
      if (term) txn_count_o <= txn_count_o + 32'd1;
      if (drop && drop_count_o != 16'hFFFF)
        drop_count_o <= drop_count_o + 16'd1;
      if (drop) overflow_o  <= 1'b1;
      if (viol) proto_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_vmon_txn_monitor.sv
// Scoreboard bench for wb_vmon_txn_monitor.
// Expected records are queued at issue time and checked when the DUT hands them out.
module tb_wb_vmon_txn_monitor;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        err;
    logic [7:0]  wt;
  } rec_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] ADR;
  logic [31:0] DAT_W;
  logic        CYC;
  logic        STB;
  logic        WE;
  logic [3:0]  SEL;
  logic        ACK;
  logic        ERR;
  logic        txn_valid_o;
  logic        txn_ready_i;
  logic [31:0] txn_adr_o;
  logic [31:0] txn_dat_o;
  logic [3:0]  txn_sel_o;
  logic        txn_we_o;
  logic        txn_err_o;
  logic [7:0]  txn_wait_o;
  logic [31:0] txn_count_o;
  logic [15:0] drop_count_o;
  logic        overflow_o;
  logic        proto_err_o;

  int   errors = 0;
  int   checks = 0;
  rec_t exp_q[$];
  rec_t act_r;
  rec_t exp_r;

  always #5 clk_i = ~clk_i;

  wb_vmon_txn_monitor #(32, 32, 8, 8) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ADR(ADR), .DAT_W(DAT_W), .CYC(CYC), .STB(STB),
    .WE(WE), .SEL(SEL), .ACK(ACK), .ERR(ERR),
    .txn_valid_o(txn_valid_o), .txn_ready_i(txn_ready_i),
    .txn_adr_o(txn_adr_o), .txn_dat_o(txn_dat_o),
    .txn_sel_o(txn_sel_o), .txn_we_o(txn_we_o),
    .txn_err_o(txn_err_o), .txn_wait_o(txn_wait_o),
    .txn_count_o(txn_count_o), .drop_count_o(drop_count_o),
    .overflow_o(overflow_o), .proto_err_o(proto_err_o)
  );

  // Monitor: every handshake observed must match the queue head.
  always @(negedge clk_i) begin
    if (rst_i && txn_valid_o && txn_ready_i) begin
      act_r = {txn_adr_o, txn_dat_o, txn_sel_o,
               txn_we_o, txn_err_o, txn_wait_o};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record adr=%h got, none required",
                 act_r.adr);
      end else begin
        exp_r = exp_q.pop_front();
        if (act_r !== exp_r) begin
          errors++;
          $display("FAIL record got adr=%h dat=%h sel=%h we=%b err=%b wt=%0d required adr=%h dat=%h sel=%h we=%b err=%b wt=%0d",
                   act_r.adr, act_r.dat, act_r.sel, act_r.we, act_r.err,
                   act_r.wt, exp_r.adr, exp_r.dat, exp_r.sel, exp_r.we,
                   exp_r.err, exp_r.wt);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_idle();
    CYC = 1'b0;
    STB = 1'b0;
    ACK = 1'b0;
    ERR = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    CYC = 1'b0;
    STB = 1'b0;
    ACK = 1'b0;
    ERR = 1'b0;
    txn_ready_i = 1'b0;
    exp_q.delete();
    repeat (5) tick();
    rst_i = 1'b1;
    tick();
  endtask

  task automatic xfer(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic w,
                      input int waits, input logic ack, input logic err,
                      input bit keep, input logic [7:0] wt);
    CYC = 1'b1;
    STB = 1'b1;
    ADR = a;
    DAT_W = d;
    SEL = s;
    WE = w;
    ACK = 1'b0;
    ERR = 1'b0;
    repeat (waits) tick();
    ACK = ack;
    ERR = err;
    if (keep) exp_q.push_back('{a, d, s, w, err, wt});
    tick();
    ACK = 1'b0;
    ERR = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", {31'd0, txn_valid_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b0;
    ADR = '0;
    DAT_W = '0;
    SEL = '0;
    WE = 1'b0;
    CYC = 1'b0;
    STB = 1'b0;
    ACK = 1'b0;
    ERR = 1'b0;
    txn_ready_i = 1'b0;

    do_reset();
    chk("rst_valid", {31'd0, txn_valid_o}, 32'd0);
    chk("rst_count", txn_count_o, 32'd0);
    chk("rst_drop", {16'd0, drop_count_o}, 32'd0);
    chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
    chk("rst_proto", {31'd0, proto_err_o}, 32'd0);
    chk("rst_adr", txn_adr_o, 32'd0);

    txn_ready_i = 1'b1;
    xfer(32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 2,
         1'b1, 1'b0, 1'b1, 8'd2);
    bus_idle();
    drain();
    chk("write_count", txn_count_o, 32'd1);
    xfer(32'h1000_0008, 32'h1234_5678, 4'h3, 1'b0, 300,
         1'b1, 1'b0, 1'b1, 8'hFF);
    bus_idle();
    drain();
    chk("satwait_count", txn_count_o, 32'd2);

    do_reset();
    txn_ready_i = 1'b1;
    xfer(32'h0, 32'h0, 4'hF, 1'b0, 0, 1'b1, 1'b0, 1'b1, 8'd0);
    xfer(32'h4, 32'h0, 4'hF, 1'b0, 0, 1'b1, 1'b0, 1'b1, 8'd0);
    xfer(32'h8, 32'h0, 4'hF, 1'b0, 0, 1'b1, 1'b0, 1'b1, 8'd0);
    bus_idle();
    drain();
    chk("burst_count", txn_count_o, 32'd3);
    xfer(32'hC, 32'h5, 4'h1, 1'b1, 1, 1'b0, 1'b1, 1'b1, 8'd1);
    bus_idle();
    drain();
    chk("errterm_count", txn_count_o, 32'd4);
    chk("errterm_proto", {31'd0, proto_err_o}, 32'd0);

    do_reset();
    for (int i = 0; i < 10; i++)
      xfer(32'h2000_0000 + 32'(4 * i), 32'hA5A5_0000 + 32'(i), 4'hF,
           1'b1, 0, 1'b1, 1'b0, i < 8, 8'd0);
    bus_idle();
    chk("ovf_count", txn_count_o, 32'd10);
    chk("ovf_drop", {16'd0, drop_count_o}, 32'd2);
    chk("ovf_flag", {31'd0, overflow_o}, 32'd1);
    chk("ovf_valid", {31'd0, txn_valid_o}, 32'd1);
    chk("ovf_head", txn_adr_o, 32'h2000_0000);
    repeat (3) tick();
    chk("ovf_head_stable", txn_adr_o, 32'h2000_0000);
    txn_ready_i = 1'b1;
    drain();

    txn_ready_i = 1'b0;
    for (int i = 0; i < 8; i++)
      xfer(32'h3000_0000 + 32'(4 * i), 32'h0000_3000 + 32'(i), 4'hC,
           1'b0, 0, 1'b1, 1'b0, 1'b1, 8'd0);
    bus_idle();
    chk("full_drop", {16'd0, drop_count_o}, 32'd2);
    txn_ready_i = 1'b1;
    xfer(32'h3000_0100, 32'h0000_3100, 4'hC, 1'b0, 0,
         1'b1, 1'b0, 1'b1, 8'd0);
    bus_idle();
    drain();
    chk("pushpop_drop", {16'd0, drop_count_o}, 32'd2);
    chk("pushpop_count", txn_count_o, 32'd19);

    txn_ready_i = 1'b0;
    xfer(32'h5000_0000, 32'h1, 4'hF, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'd0);
    xfer(32'h5000_0004, 32'h2, 4'hF, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'd0);
    bus_idle();
    do_reset();
    chk("rst2_valid", {31'd0, txn_valid_o}, 32'd0);
    chk("rst2_count", txn_count_o, 32'd0);
    chk("rst2_ovf", {31'd0, overflow_o}, 32'd0);

    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    tick();
    chk("proto_flag", {31'd0, proto_err_o}, 32'd1);
    chk("proto_norec", {31'd0, txn_valid_o}, 32'd0);
    chk("proto_count", txn_count_o, 32'd0);
    txn_ready_i = 1'b1;
    xfer(32'h4000_0000, 32'hCAFE_F00D, 4'h5, 1'b1, 0,
         1'b1, 1'b1, 1'b1, 8'd0);
    bus_idle();
    drain();
    chk("ackerr_count", txn_count_o, 32'd1);
    chk("proto_sticky", {31'd0, proto_err_o}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
